arcade_input_mapper: RTL and testbench
======================================

Name: arcade_input_mapper

Overview:
- Parametrised front-end that turns MiSTer joystick words and PS/2 key events into per-player arcade control signals for any core top-level.
- Generalises the single-core keyboard/joystick merge to 1-4 players, N fire buttons, four rotation modes and opposite-direction cancel.
- Adds timed coin pulses with lockout.
- Sits between hps_io and the game core; runs entirely on clk_sys.

Parameters:
- PLAYERS, 2, number of players (1-4).
- NBTN, 2, fire buttons per player (1-6).
- COIN_PULSE, 1200000, coin pulse length and lockout length in clk_sys cycles; must be at least 1.
- SOCD_CLEAR, 1, when 1 opposite directions held together both read 0.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- joystick  in  16*PLAYERS  MiSTer joystick word per player. Bits: 0 right, 1 left, 2 down, 3 up, 4..3+NBTN fire, 4+NBTN start, 5+NBTN coin.
- ps2_key  in  11  bit 10 toggle, bit 9 pressed, bit 8 extended, bits 7:0 scan code
- rot  in  2  0 none, 1 CW, 2 CCW, 3 180
- coin_on_start  in  1  a start press also requests that player's coin
- dir  out  4*PLAYERS  per player {up,down,left,right}, registered
- fire  out  NBTN*PLAYERS  registered fire buttons
- start  out  PLAYERS  registered start
- coin  out  PLAYERS  coin pulses
- test  out  1  service/test key level

Behaviour:
- Reset: all outputs 0, key-state register 0, coin counters 0, toggle tracker 0.
- Keyboard event: a change of ps2_key[10] versus its registered copy is an event.
  - The key-state register updates the next cycle with pressed = ps2_key[9].
  - Outputs reflect it one cycle later: 2-cycle latency from the toggle edge.
- Key map (extended bit is don't-care unless stated):
  - P1: up E075, down E072, left E06B, right E074; fire0 LCtrl 14 or Space 29; fire1 LAlt 11.
  - P2: up 2D (R), down 2B (F), left 23 (D), right 34 (G); fire0 1C (A); fire1 1B (S).
  - Starts 16/1E/26/25 (keys 1-4); F1 05 and F2 06 alias start1/start2.
  - Coins 2E/36/3D/3E (keys 5-8).
  - Test 2C (T).
  - Keys for players ≥ PLAYERS and fire buttons ≥ NBTN are ignored.
- Merge: per-player raw = key bits OR joystick bits. Players 3-4 are joystick-only for direction and fire.
- Rotation is applied to the raw {u,d,l,r}:
  - rot=1: u←l, d←r, l←d, r←u.
  - rot=2: u←r, d←l, l←u, r←d.
  - rot=3: u←d, d←u, l←r, r←l.
- SOCD is applied after rotation: u&d→both 0, l&r→both 0.
- Registered: joystick-to-output latency is 1 cycle.
- Coin pulser, per player:
  - Request = key coin OR joystick coin OR (coin_on_start AND start).
  - A rising edge of the request while IDLE starts PULSE: coin=1 for exactly COIN_PULSE cycles.
  - Then LOCK for COIN_PULSE cycles with coin=0, then back to IDLE.
  - Edges during PULSE or LOCK are dropped, not queued.
  - A request held high across LOCK→IDLE does not retrigger; a new rising edge is required.
  - Counter width is $clog2(COIN_PULSE+1).
- Simultaneous events: key press and joystick release on the same bit → the OR rule applies.
- Reset asserted mid-pulse: coin drops asynchronously, state returns to IDLE.

Optional Feature:
- Macro: ARCADE_INPUT_AUTOFIRE_EN.
- When defined:
  - Adds input autofire[PLAYERS-1:0] and parameter AF_HALF, default 120000 cycles.
  - While autofire[p]=1 and fire0 is raw-held, fire0 output toggles every AF_HALF cycles, starting at 1 on the press cycle.
  - The shared phase counter resets when fire0 is released.
- When undefined: the port and parameter are absent and fire0 passes straight through.

Decomposition:
- Package arcade_input_pkg holds:
  - scan-code localparams;
  - rot_e enum (ROT_NONE, ROT_CW, ROT_CCW, ROT_180);
  - direction bit indices DIR_U/D/L/R;
  - joystick bit index function jbit_start(NBTN)/jbit_coin(NBTN).
- One sub-module coin_pulser (params COIN_PULSE; ports clk_sys, reset_n, req, pulse), generated per player.

Test Plan:
- Reset: hold reset_n=0 with all joystick bits 1 → every output 0; release → dir/fire follow joystick after 1 cycle.
- PS/2: toggle ps2_key[10] with 9'h175 pressed → dir[3] (P1 up)=1 two cycles after the toggle; release event → 0 two cycles later.
- Rotation: rot=1, joystick[1]=1 (P1 left) → P1 up=1; rot=3 → P1 right=1; rot=2 → P1 down=1.
- SOCD: P1 up key and joystick down together with SOCD_CLEAR=1 → both 0; with SOCD_CLEAR=0 → both 1.
- Coin: COIN_PULSE=4, coin key pressed → coin[0]=1 for exactly 4 cycles, then 0.
  - A second press at cycle 6 is ignored.
  - A press at cycle 10 produces a new pulse.
- Coin-on-start with reset mid-pulse: coin_on_start=1, start2 via key 1E → coin[1] pulses; asserting reset_n=0 during the pulse clears coin[1] immediately.

Source files
------------

// File: rtl/arcade_input_pkg.sv
// Shared constants for arcade_input_mapper: PS/2 scan codes, key-state indices,
// rotation modes, direction bit positions and joystick word layout helpers.
package arcade_input_pkg;

  typedef enum logic [1:0] {
    ROT_NONE = 2'd0,
    ROT_CW   = 2'd1,
    ROT_CCW  = 2'd2,
    ROT_180  = 2'd3
  } rot_e;

  // Direction nibble is {up,down,left,right}, same order as the joystick word.
  localparam int unsigned DIR_R = 0;
  localparam int unsigned DIR_L = 1;
  localparam int unsigned DIR_D = 2;
  localparam int unsigned DIR_U = 3;

  localparam logic [7:0] SC_P1_UP    = 8'h75;
  localparam logic [7:0] SC_P1_DOWN  = 8'h72;
  localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
  localparam logic [7:0] SC_P1_RIGHT = 8'h74;
  localparam logic [7:0] SC_LCTRL    = 8'h14;
  localparam logic [7:0] SC_SPACE    = 8'h29;
  localparam logic [7:0] SC_LALT     = 8'h11;
  localparam logic [7:0] SC_P2_UP    = 8'h2D;
  localparam logic [7:0] SC_P2_DOWN  = 8'h2B;
  localparam logic [7:0] SC_P2_LEFT  = 8'h23;
  localparam logic [7:0] SC_P2_RIGHT = 8'h34;
  localparam logic [7:0] SC_P2_FIRE0 = 8'h1C;
  localparam logic [7:0] SC_P2_FIRE1 = 8'h1B;
  localparam logic [7:0] SC_START1   = 8'h16;
  localparam logic [7:0] SC_START2   = 8'h1E;
  localparam logic [7:0] SC_START3   = 8'h26;
  localparam logic [7:0] SC_START4   = 8'h25;
  localparam logic [7:0] SC_F1       = 8'h05;
  localparam logic [7:0] SC_F2       = 8'h06;
  localparam logic [7:0] SC_COIN1    = 8'h2E;
  localparam logic [7:0] SC_COIN2    = 8'h36;
  localparam logic [7:0] SC_COIN3    = 8'h3D;
  localparam logic [7:0] SC_COIN4    = 8'h3E;
  localparam logic [7:0] SC_TEST     = 8'h2C;

  // Key-state register bit positions; LCtrl and Space keep separate bits.
  localparam int unsigned K_P1U    = 0;
  localparam int unsigned K_P1D    = 1;
  localparam int unsigned K_P1L    = 2;
  localparam int unsigned K_P1R    = 3;
  localparam int unsigned K_P1F0A  = 4;
  localparam int unsigned K_P1F0B  = 5;
  localparam int unsigned K_P1F1   = 6;
  localparam int unsigned K_P2U    = 7;
  localparam int unsigned K_P2D    = 8;
  localparam int unsigned K_P2L    = 9;
  localparam int unsigned K_P2R    = 10;
  localparam int unsigned K_P2F0   = 11;
  localparam int unsigned K_P2F1   = 12;
  localparam int unsigned K_START1 = 13;
  localparam int unsigned K_F1     = 17;
  localparam int unsigned K_F2     = 18;
  localparam int unsigned K_COIN1  = 19;
  localparam int unsigned K_TEST   = 23;
  localparam int unsigned NKEY     = 24;

  function automatic int unsigned jbit_start(input int unsigned nbtn);
    return 4 + nbtn;
  endfunction

  function automatic int unsigned jbit_coin(input int unsigned nbtn);
    return 5 + nbtn;
  endfunction

  // One-hot key-state mask for a scan code; P1 arrows require the E0 prefix.
  function automatic logic [NKEY-1:0] key_mask(input logic ext, input logic [7:0] code);
    logic [NKEY-1:0] m;
    m = '0;
    case (code)
      SC_P1_UP:    m[K_P1U]      = ext;
      SC_P1_DOWN:  m[K_P1D]      = ext;
      SC_P1_LEFT:  m[K_P1L]      = ext;
      SC_P1_RIGHT: m[K_P1R]      = ext;
      SC_LCTRL:    m[K_P1F0A]    = 1'b1;
      SC_SPACE:    m[K_P1F0B]    = 1'b1;
      SC_LALT:     m[K_P1F1]     = 1'b1;
      SC_P2_UP:    m[K_P2U]      = 1'b1;
      SC_P2_DOWN:  m[K_P2D]      = 1'b1;
      SC_P2_LEFT:  m[K_P2L]      = 1'b1;
      SC_P2_RIGHT: m[K_P2R]      = 1'b1;
      SC_P2_FIRE0: m[K_P2F0]     = 1'b1;
      SC_P2_FIRE1: m[K_P2F1]     = 1'b1;
      SC_START1:   m[K_START1]   = 1'b1;
      SC_START2:   m[K_START1+1] = 1'b1;
      SC_START3:   m[K_START1+2] = 1'b1;
      SC_START4:   m[K_START1+3] = 1'b1;
      SC_F1:       m[K_F1]       = 1'b1;
      SC_F2:       m[K_F2]       = 1'b1;
      SC_COIN1:    m[K_COIN1]    = 1'b1;
      SC_COIN2:    m[K_COIN1+1]  = 1'b1;
      SC_COIN3:    m[K_COIN1+2]  = 1'b1;
      SC_COIN4:    m[K_COIN1+3]  = 1'b1;
      SC_TEST:     m[K_TEST]     = 1'b1;
      default:     m             = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/arcade_input_mapper_coin_pulser.sv
// Coin pulser: a request rising edge in IDLE gives COIN_PULSE cycles of pulse,
// then COIN_PULSE cycles of lockout; edges outside IDLE are dropped.
module coin_pulser #(
  parameter int unsigned COIN_PULSE = 1200000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic req,
  output logic pulse
);

  localparam int unsigned CW = $clog2(COIN_PULSE + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_LOCK} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            req_q;
  logic            pulse_q, pulse_d;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req && !req_q) begin
          state_d = ST_PULSE;
          cnt_d   = CW'(COIN_PULSE - 1);
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_LOCK;
          cnt_d   = CW'(COIN_PULSE - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_LOCK: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    pulse_d = (state_d == ST_PULSE);
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/arcade_input_mapper.sv
// Merges MiSTer joystick words and PS/2 key events into per-player arcade controls.
// Optional autofire on fire0 is built when ARCADE_INPUT_AUTOFIRE_EN is defined.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int unsigned PLAYERS    = 2,
  parameter int unsigned NBTN       = 2,
  parameter int unsigned COIN_PULSE = 1200000,
  parameter int unsigned SOCD_CLEAR = 1
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  ,
  parameter int unsigned AF_HALF    = 120000
`endif
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic [16*PLAYERS-1:0]   joystick,
  input  logic [10:0]             ps2_key,
  input  logic [1:0]              rot,
  input  logic                    coin_on_start,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  input  logic [PLAYERS-1:0]      autofire,
`endif
  output logic [4*PLAYERS-1:0]    dir,
  output logic [NBTN*PLAYERS-1:0] fire,
  output logic [PLAYERS-1:0]      start,
  output logic [PLAYERS-1:0]      coin,
  output logic                    test
);

  localparam int unsigned JB_START = jbit_start(NBTN);
  localparam int unsigned JB_COIN  = jbit_coin(NBTN);

  logic                    toggle_q, toggle_d;
  logic [NKEY-1:0]         keys_q, keys_d, key_sel;
  logic [4*PLAYERS-1:0]    dir_q, dir_d;
  logic [NBTN*PLAYERS-1:0] fire_q, fire_d;
  logic [PLAYERS-1:0]      start_q, start_d;
  logic                    test_q, test_d;
  logic                    unused_keys;

  assign key_sel     = key_mask(ps2_key[8], ps2_key[7:0]);
  assign unused_keys = ^keys_q;

  // A toggle-bit change is one key event; pressed sets, released clears.
  always_comb begin
    toggle_d = ps2_key[10];
    keys_d   = keys_q;
    if (ps2_key[10] != toggle_q) begin
      keys_d = ps2_key[9] ? (keys_q | key_sel) : (keys_q & ~key_sel);
    end
    test_d = keys_q[K_TEST];
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q <= 1'b0;
      keys_q   <= '0;
      dir_q    <= '0;
      fire_q   <= '0;
      start_q  <= '0;
      test_q   <= 1'b0;
    end else begin
      toggle_q <= toggle_d;
      keys_q   <= keys_d;
      dir_q    <= dir_d;
      fire_q   <= fire_d;
      start_q  <= start_d;
      test_q   <= test_d;
    end
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic [15:0]     jw;
    logic [3:0]      kd, raw, rdir, sdir;
    logic [5:0]      kf;
    logic [NBTN-1:0] fraw, fout;
    logic            kstart, kcoin, sraw, fire0;
    logic            unused_bits;

    assign jw          = joystick[16*p +: 16];
    assign unused_bits = ^{jw, kf};
    assign kcoin       = keys_q[K_COIN1+p];

    // Only players 1 and 2 have keyboard directions and fire buttons.
    if (p == 0) begin : g_kb1
      assign kd     = {keys_q[K_P1U], keys_q[K_P1D], keys_q[K_P1L], keys_q[K_P1R]};
      assign kf     = {4'b0, keys_q[K_P1F1], keys_q[K_P1F0A] | keys_q[K_P1F0B]};
      assign kstart = keys_q[K_START1] | keys_q[K_F1];
    end else if (p == 1) begin : g_kb2
      assign kd     = {keys_q[K_P2U], keys_q[K_P2D], keys_q[K_P2L], keys_q[K_P2R]};
      assign kf     = {4'b0, keys_q[K_P2F1], keys_q[K_P2F0]};
      assign kstart = keys_q[K_START1+1] | keys_q[K_F2];
    end else begin : g_kbn
      assign kd     = '0;
      assign kf     = '0;
      assign kstart = keys_q[K_START1+p];
    end

    assign raw  = kd | jw[3:0];
    assign fraw = kf[NBTN-1:0] | jw[4 +: NBTN];
    assign sraw = kstart | jw[JB_START];

    // Rotate first, then cancel opposite directions.
    always_comb begin
      case (rot_e'(rot))
        ROT_CW:  rdir = {raw[DIR_L], raw[DIR_R], raw[DIR_D], raw[DIR_U]};
        ROT_CCW: rdir = {raw[DIR_R], raw[DIR_L], raw[DIR_U], raw[DIR_D]};
        ROT_180: rdir = {raw[DIR_D], raw[DIR_U], raw[DIR_R], raw[DIR_L]};
        default: rdir = raw;
      endcase
      sdir = rdir;
      if (SOCD_CLEAR != 0) begin
        if (rdir[DIR_U] && rdir[DIR_D]) begin
          sdir[DIR_U] = 1'b0;
          sdir[DIR_D] = 1'b0;
        end
        if (rdir[DIR_L] && rdir[DIR_R]) begin
          sdir[DIR_L] = 1'b0;
          sdir[DIR_R] = 1'b0;
        end
      end
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    localparam int unsigned AW = $clog2(AF_HALF + 1);
    logic [AW-1:0] af_cnt_q, af_cnt_d;
    logic          af_ph_q, af_ph_d;

    // Phase restarts high on release so the press cycle always fires.
    always_comb begin
      af_cnt_d = '0;
      af_ph_d  = 1'b1;
      if (fraw[0]) begin
        af_cnt_d = af_cnt_q + AW'(1);
        af_ph_d  = af_ph_q;
        if (af_cnt_q == AW'(AF_HALF - 1)) begin
          af_cnt_d = '0;
          af_ph_d  = ~af_ph_q;
        end
      end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        af_cnt_q <= '0;
        af_ph_q  <= 1'b1;
      end else begin
        af_cnt_q <= af_cnt_d;
        af_ph_q  <= af_ph_d;
      end
    end

    assign fire0 = autofire[p] ? (fraw[0] & af_ph_q) : fraw[0];
`else
    assign fire0 = fraw[0];
`endif

    always_comb begin
      fout    = fraw;
      fout[0] = fire0;
    end

    assign dir_d[4*p +: 4]       = sdir;
    assign fire_d[NBTN*p +: NBTN] = fout;
    assign start_d[p]            = sraw;

    coin_pulser #(
      .COIN_PULSE (COIN_PULSE)
    ) u_coin (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .req     (kcoin | jw[JB_COIN] | (coin_on_start & sraw)),
      .pulse   (coin[p])
    );
  end

  assign dir   = dir_q;
  assign fire  = fire_q;
  assign start = start_q;
  assign test  = test_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper: reset, PS/2 latency, key map,
// rotation, SOCD on/off, coin pulse/lockout and asynchronous reset mid-pulse.
module tb_arcade_input_mapper;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] joystick;
  logic [10:0] ps2_key;
  logic [1:0]  rot;
  logic        coin_on_start;
  logic        tgl;

  logic [7:0]  dir, dir_ns;
  logic [3:0]  fire, fire_ns;
  logic [1:0]  start, start_ns, coin, coin_ns;
  logic        test, test_ns;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  arcade_input_mapper #(
    .PLAYERS(2), .NBTN(2), .COIN_PULSE(4), .SOCD_CLEAR(1)
  ) dut (
    .clk_sys(clk), .reset_n(reset_n), .joystick(joystick), .ps2_key(ps2_key),
    .rot(rot), .coin_on_start(coin_on_start),
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    .autofire(2'b00),
`endif
    .dir(dir), .fire(fire), .start(start), .coin(coin), .test(test)
  );

  arcade_input_mapper #(
    .PLAYERS(2), .NBTN(2), .COIN_PULSE(4), .SOCD_CLEAR(0)
  ) dut_ns (
    .clk_sys(clk), .reset_n(reset_n), .joystick(joystick), .ps2_key(ps2_key),
    .rot(rot), .coin_on_start(coin_on_start),
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    .autofire(2'b00),
`endif
    .dir(dir_ns), .fire(fire_ns), .start(start_ns), .coin(coin_ns), .test(test_ns)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one PS/2 event and let one rising edge register it.
  task automatic key(input logic pr, input logic ext, input logic [7:0] code);
    tgl     = ~tgl;
    ps2_key = {tgl, pr, ext, code};
    @(negedge clk);
  endtask

  initial begin
    reset_n       = 1'b0;
    joystick      = 32'hFFFF_FFFF;
    ps2_key       = '0;
    tgl           = 1'b0;
    rot           = 2'd0;
    coin_on_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dir",   32'(dir),   32'h0);
    chk("rst_fire",  32'(fire),  32'h0);
    chk("rst_start", 32'(start), 32'h0);
    chk("rst_coin",  32'(coin),  32'h0);
    chk("rst_test",  32'(test),  32'h0);

    // P1 up+right+fire0, P2 left+fire1
    joystick = 32'h0022_0019;
    reset_n  = 1'b1;
    @(negedge clk);
    chk("joy_dir",  32'(dir),  32'h29);
    chk("joy_fire", 32'(fire), 32'h9);
    joystick = 32'h0;
    @(negedge clk);
    chk("joy_clear", 32'(dir), 32'h0);

    key(1'b1, 1'b1, 8'h75);
    chk("ps2_lat1", 32'(dir), 32'h0);
    @(negedge clk);
    chk("ps2_up", 32'(dir), 32'h08);
    key(1'b0, 1'b1, 8'h75);
    chk("ps2_rel_lat1", 32'(dir), 32'h08);
    @(negedge clk);
    chk("ps2_rel", 32'(dir), 32'h0);

    key(1'b1, 1'b0, 8'h75);
    @(negedge clk);
    chk("ps2_noext_ignored", 32'(dir), 32'h0);
    key(1'b0, 1'b0, 8'h75);

    key(1'b1, 1'b0, 8'h29);
    @(negedge clk);
    chk("key_space_fire0", 32'(fire), 32'h1);
    key(1'b1, 1'b0, 8'h2C);
    @(negedge clk);
    chk("key_test", 32'(test), 32'h1);
    key(1'b0, 1'b0, 8'h29);
    key(1'b0, 1'b0, 8'h2C);
    @(negedge clk);
    chk("key_fire_rel", 32'(fire), 32'h0);
    chk("key_test_rel", 32'(test), 32'h0);
    key(1'b1, 1'b0, 8'h2D);
    @(negedge clk);
    chk("key_p2_up", 32'(dir), 32'h80);
    key(1'b0, 1'b0, 8'h2D);
    @(negedge clk);

    joystick = 32'h2;
    rot = 2'd1;
    @(negedge clk);
    chk("rot_cw", 32'(dir), 32'h08);
    rot = 2'd3;
    @(negedge clk);
    chk("rot_180", 32'(dir), 32'h01);
    rot = 2'd2;
    @(negedge clk);
    chk("rot_ccw", 32'(dir), 32'h04);
    rot = 2'd0;
    joystick = 32'h0;
    @(negedge clk);

    joystick = 32'h4;
    key(1'b1, 1'b1, 8'h75);
    @(negedge clk);
    chk("socd_ud_clear", 32'(dir),    32'h00);
    chk("socd_ud_off",   32'(dir_ns), 32'h0C);
    joystick = 32'h3;
    @(negedge clk);
    chk("socd_lr_clear", 32'(dir),    32'h08);
    chk("socd_lr_off",   32'(dir_ns), 32'h0B);
    joystick = 32'h0;
    key(1'b0, 1'b1, 8'h75);
    @(negedge clk);

    key(1'b1, 1'b0, 8'h2E);
    chk("coin_lat", 32'(coin), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("coin_pulse", 32'(coin), 32'h1);
    end
    @(negedge clk);
    chk("coin_end", 32'(coin), 32'h0);
    key(1'b0, 1'b0, 8'h2E);
    @(negedge clk);
    joystick = 32'h80;
    @(negedge clk);
    chk("coin_lock_drop", 32'(coin), 32'h0);
    joystick = 32'h0;
    @(negedge clk);
    chk("coin_lock_idle", 32'(coin), 32'h0);
    joystick = 32'h80;
    @(negedge clk);
    chk("coin_retrig", 32'(coin), 32'h1);
    repeat (3) @(negedge clk);
    chk("coin_retrig_hold", 32'(coin), 32'h1);
    @(negedge clk);
    chk("coin_retrig_end", 32'(coin), 32'h0);
    repeat (10) @(negedge clk);
    chk("coin_held_no_retrig", 32'(coin), 32'h0);
    joystick = 32'h0;
    repeat (2) @(negedge clk);

    coin_on_start = 1'b1;
    key(1'b1, 1'b0, 8'h1E);
    @(negedge clk);
    chk("cos_start2", 32'(start), 32'h2);
    chk("cos_coin2",  32'(coin),  32'h2);
    @(negedge clk);
    chk("cos_coin2_hold", 32'(coin), 32'h2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("cos_async_rst_coin",  32'(coin),  32'h0);
    chk("cos_async_rst_start", 32'(start), 32'h0);
    ps2_key       = '0;
    tgl           = 1'b0;
    coin_on_start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_coin",  32'(coin),  32'h0);
    chk("post_rst_start", 32'(start), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
